// File: rtl/nibble_seq_adder_pkg.sv
// Shared constants for the nibble-serial adder: slice width and FSM state encoding.
package nibble_seq_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_seq_adder_if.sv
// Request/result bundle between one requester (master) and the nibble-serial adder (slave).
interface nibble_seq_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;

    modport master (
        output start, sub, a, b, ci,
        input  busy, done, sum, co, ov
    );

    modport slave (
        input  start, sub, a, b, ci,
        output busy, done, sum, co, ov
    );

endinterface

// File: rtl/nibble_seq_adder_add4.sv
// Purely combinational 4-bit ripple-carry slice, reused once per nibble by the sequencer.
module add4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, ci_i};

endmodule

// File: rtl/nibble_seq_adder.sv
// Wide add/subtract built from one add4 slice stepped LS nibble first, carry held between steps.
module nibble_seq_adder
    import nibble_seq_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    nibble_seq_adder_if.slave bus
);

    localparam int                W        = NIB_W * NIBBLES;
    localparam int                IDX_W    = $clog2(NIBBLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     opb_q, opb_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [NIB_W-1:0] slice_a, slice_b, slice_s;
    logic             slice_co;

    always_comb begin
        slice_a = opa_q[NIB_W*int'(idx_q) +: NIB_W];
        slice_b = opb_q[NIB_W*int'(idx_q) +: NIB_W];
    end

    add4 u_add4 (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .ci_i (carry_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path through the case infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1, so the inverted B and forced carry are latched here.
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.ci;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[NIB_W*int'(idx_q) +: NIB_W] = slice_s;
                carry_d = slice_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    co_d    = slice_co;
                    ov_d    = (opa_q[W-1] ~^ opb_q[W-1]) & (slice_s[NIB_W-1] ^ opa_q[W-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.ov   = ov_q;

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Directed scoreboard bench: drivers push expected results, negedge monitors pop on done.
module tb_nibble_seq_adder;

    logic clk;
    logic rst;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_seq_adder_if #(.NIBBLES(4)) bus4 ();
    nibble_seq_adder_if #(.NIBBLES(1)) bus1 ();

    nibble_seq_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    nibble_seq_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t       q4[$];
    exp_t       q1[$];
    exp_t       e4, e1;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] prev4 = 2'b00;
    logic [1:0] prev1 = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: compare the result presented on every done pulse against the queue head.
    always @(negedge clk) begin
        if (bus4.done === 1'b1) begin
            if (q4.size() == 0) begin
                check("dut4 unexpected done", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("dut4 sum", bus4.sum, e4.sum);
                check("dut4 co", bus4.co, e4.co);
                check("dut4 ov", bus4.ov, e4.ov);
                check("dut4 done cycle", cyc, e4.cyc);
                check("dut4 busy at done", bus4.busy, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.done === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected done", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut1 sum", bus1.sum, e1.sum);
                check("dut1 co", bus1.co, e1.co);
                check("dut1 ov", bus1.ov, e1.ov);
                check("dut1 done cycle", cyc, e1.cyc);
            end
        end
    end

    task automatic push4(input logic [15:0] es, input logic eco, input logic eov, input int dc);
        exp_t e;
        e.sum = es; e.co = eco; e.ov = eov; e.cyc = dc;
        q4.push_back(e);
    endtask

    task automatic wait_idle4();
        for (int i = 0; i < 20 && bus4.busy === 1'b1; i++) @(negedge clk);
        check("dut4 returns idle", bus4.busy, 0);
    endtask

    task automatic op4(input logic s, input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic eco, input logic eov);
        int nb;
        @(negedge clk);
        bus4.start = 1'b1; bus4.sub = s; bus4.a = a; bus4.b = b; bus4.ci = c;
        push4(es, eco, eov, cyc + 5);
        @(negedge clk);
        // Scramble inputs: only the latched copies may matter from here on.
        bus4.start = 1'b0; bus4.sub = ~s; bus4.a = ~a; bus4.b = ~b; bus4.ci = ~c;
        check("dut4 sum cleared at accept", bus4.sum, 0);
        check("dut4 co/ov held at accept", {bus4.co, bus4.ov}, prev4);
        nb = 0;
        for (int i = 0; i < 20 && bus4.busy === 1'b1; i++) begin
            nb++;
            @(negedge clk);
        end
        check("dut4 busy cycles", nb, 5);
        check("dut4 sum held after done", bus4.sum, es);
        prev4 = {eco, eov};
    endtask

    task automatic op1(input logic s, input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] es, input logic eco, input logic eov);
        exp_t e;
        int   nb;
        @(negedge clk);
        bus1.start = 1'b1; bus1.sub = s; bus1.a = a; bus1.b = b; bus1.ci = c;
        e.sum = {12'h000, es}; e.co = eco; e.ov = eov; e.cyc = cyc + 2;
        q1.push_back(e);
        @(negedge clk);
        bus1.start = 1'b0; bus1.a = ~a; bus1.b = ~b; bus1.ci = ~c;
        check("dut1 co/ov held at accept", {bus1.co, bus1.ov}, prev1);
        nb = 0;
        for (int i = 0; i < 20 && bus1.busy === 1'b1; i++) begin
            nb++;
            @(negedge clk);
        end
        check("dut1 busy cycles", nb, 2);
        check("dut1 sum held after done", bus1.sum, es);
        prev1 = {eco, eov};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.ci = 1'b0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", bus4.busy, 0);
        check("reset done", bus4.done, 0);
        check("reset sum", bus4.sum, 0);
        check("reset co/ov", {bus4.co, bus4.ov}, 0);
        check("dut1 reset busy", bus1.busy, 0);
        rst = 1'b0;

        op4(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        op4(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op4(1'b0, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
        op4(1'b1, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b1, 1'b0);
        op4(1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        op4(1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
        op4(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op4(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Starts during RUN and DONE are ignored; a start in the following IDLE cycle is taken.
        @(negedge clk);
        bus4.start = 1'b1; bus4.sub = 1'b0; bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.ci = 1'b0;
        push4(16'h3333, 1'b0, 1'b0, cyc + 5);
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 16'hAAAA; bus4.b = 16'h5555;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        bus4.start = 1'b1; bus4.a = 16'hFFFF; bus4.b = 16'hFFFF; bus4.ci = 1'b1;
        @(negedge clk);
        check("busy low in idle after done", bus4.busy, 0);
        check("result intact after ignored starts", bus4.sum, 16'h3333);
        bus4.a = 16'h0F0F; bus4.b = 16'h0101; bus4.ci = 1'b0;
        push4(16'h1010, 1'b0, 1'b0, cyc + 5);
        @(negedge clk);
        bus4.start = 1'b0;
        wait_idle4();
        @(negedge clk);
        check("back-to-back result", bus4.sum, 16'h1010);
        prev4 = 2'b00;

        // Leave co/ov set, then abort an operation at nibble step 2 with reset.
        op4(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);
        bus4.start = 1'b1; bus4.sub = 1'b0; bus4.a = 16'h1234; bus4.b = 16'h1111; bus4.ci = 1'b0;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", bus4.busy, 0);
        check("abort done", bus4.done, 0);
        check("abort sum", bus4.sum, 0);
        check("abort co/ov", {bus4.co, bus4.ov}, 0);
        prev4 = 2'b00;
        repeat (6) @(negedge clk);
        check("abort stays idle", bus4.busy, 0);

        op1(1'b0, 4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0);
        op1(1'b1, 4'h3, 4'h5, 1'b0, 4'hE, 1'b0, 1'b0);
        op1(1'b0, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        op1(1'b1, 4'h8, 4'h1, 1'b0, 4'h7, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check("dut4 scoreboard drained", q4.size(), 0);
        check("dut1 scoreboard drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
